period_meter: RTL and testbench

- Measures the period and high time of a slow, asynchronous input such as the divided CPU step clock or an external square wave.
- Counts are in clk_i cycles.
- This is the receiving end of the clock-divider path: it consumes a slow clock and reports its timing back into the fast domain.
- Results are delivered through a valid/ready register slice, with timeout and overrun status flags.

---
 rtl/period_meter_pkg.sv | 14 +
 rtl/period_meter_if.sv | 34 +++
 rtl/period_meter_sync_edge.sv | 31 +++
 rtl/period_meter.sv | 122 ++++++++++++
 tb/tb_period_meter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/period_meter_pkg.sv
// period_meter shared types and defaults.
// Imported by the synchroniser, the result interface and the top.
package period_meter_pkg;

  typedef enum logic {
    IDLE,
    MEAS
  } state_e;

  localparam int CNT_W_DEF   = 32;
  localparam int TIMEOUT_DEF = 200_000_000;
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/period_meter_if.sv
// Result bundle of period_meter: data, valid/ready and status flags.
// master drives results, slave consumes them.
interface period_meter_if
  import period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             ready_i;
  logic             timeout_o;
  logic             overrun_o;

  modport master (
    output period_o,
    output high_o,
    output valid_o,
    output timeout_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  period_o,
    input  high_o,
    input  valid_o,
    input  timeout_o,
    input  overrun_o,
    output ready_i
  );

endinterface

// File: rtl/period_meter_sync_edge.sv
// Synchronises an asynchronous level and derives rise/fall pulses.
// Reusable by any consumer of a slow clock in the fast domain.
module sync_edge
  import period_meter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall,
  output logic o_lvl
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_lvl  = r_sync[SYNC_STAGES-1];
  assign o_rise = o_lvl & ~r_hist;
  assign o_fall = ~o_lvl & r_hist;

endmodule

// File: rtl/period_meter.sv
// Period / high-time meter for a slow asynchronous input.
// Results leave through a registered valid/ready slice.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          sig_i,
  period_meter_if.master res
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic w_rise;
  logic w_lvl;
  logic w_fall_unused;

  sync_edge u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_sig  (sig_i),
    .o_rise (w_rise),
    .o_fall (w_fall_unused),
    .o_lvl  (w_lvl)
  );

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_pcnt, w_pcnt_nxt;
  logic [CNT_W-1:0] r_hcnt, w_hcnt_nxt;
  logic             w_cap;
  logic             w_to;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_hcnt_nxt  = r_hcnt;
    w_cap       = 1'b0;
    w_to        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pcnt_nxt = '0;
        w_hcnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = MEAS;
          w_pcnt_nxt  = ONE;
          w_hcnt_nxt  = ONE;
        end
      end
      MEAS: begin
        if (w_rise) begin
          w_cap      = 1'b1;
          w_pcnt_nxt = ONE;
          w_hcnt_nxt = ONE;
        end else if (r_pcnt == TO_LIM) begin
          w_state_nxt = IDLE;
          w_to        = 1'b1;
          w_pcnt_nxt  = '0;
          w_hcnt_nxt  = '0;
        end else begin
          w_pcnt_nxt = r_pcnt + ONE;
          w_hcnt_nxt = r_hcnt + CNT_W'(w_lvl);
        end
      end
    endcase
  end

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic             r_valid;
  logic             r_timeout;
  logic             r_overrun;

  // A capture frees the slot itself when the consumer takes it the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_cap) begin
      r_timeout <= 1'b0;
      if (!r_valid || res.ready_i) begin
        r_period <= r_pcnt;
        r_high   <= r_hcnt;
        r_valid  <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else begin
      if (w_to) begin
        r_timeout <= 1'b1;
      end
      if (r_valid && res.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign res.period_o  = r_period;
  assign res.high_o    = r_high;
  assign res.valid_o   = r_valid;
  assign res.timeout_o = r_timeout;
  assign res.overrun_o = r_overrun;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with a result scoreboard.
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_period_meter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sig   = 1'b0;

  always #5 clk = ~clk;

  period_meter_if #(.CNT_W(32)) bus ();

  period_meter #(
    .CNT_W   (32),
    .TIMEOUT (50)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sig_i  (sig),
    .res    (bus)
  );

  int vec  = 0;
  int errs = 0;

  logic [63:0] sb[$];
  logic [63:0] exp_res;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // n rising edges; each completed period is pushed at the next rise
  task automatic wave(input int hi, input int lo,
                      input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      if (push && i > 0)
        sb.push_back({32'(hi + lo), 32'(hi)});
      sig = 1'b1;
      step(hi);
      sig = 1'b0;
      step(lo);
    end
  endtask

  task automatic gap();
    sig = 1'b0;
    step(60);
  endtask

  // one comparison per accepted transfer
  always @(negedge clk) begin
    if (rst_n && bus.valid_o && bus.ready_i) begin
      if (sb.size() == 0) exp_res = '1;
      else exp_res = sb.pop_front();
      vec++;
      assert ({bus.period_o, bus.high_o} === exp_res) else begin
        errs++;
        $error("FAIL xfer got=%0d/%0d exp=%0d/%0d",
               bus.period_o, bus.high_o,
               exp_res[63:32], exp_res[31:0]);
      end
    end
  end

  initial begin
    bus.ready_i = 1'b0;
    rst_n = 1'b0;
    sig = 1'b0;
    repeat (6) begin
      sig = ~sig;
      step(3);
    end
    chk("rst_valid", 32'(bus.valid_o), 0);
    chk("rst_to", 32'(bus.timeout_o), 0);
    chk("rst_ovr", 32'(bus.overrun_o), 0);
    chk("rst_period", bus.period_o, 0);
    chk("rst_high", bus.high_o, 0);
    sig = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    bus.ready_i = 1'b1;
    sig = 1'b1;
    step(10);
    sig = 1'b0;
    step(20);
    chk("first_rise_novalid", 32'(bus.valid_o), 0);
    gap();

    wave(10, 10, 4, 1'b1);
    gap();
    wave(1, 6, 3, 1'b1);
    gap();
    wave(6, 1, 3, 1'b1);
    gap();
    chk("drain1", 32'(sb.size()), 0);

    bus.ready_i = 1'b0;
    wave(10, 10, 4, 1'b0);
    sb.push_back({32'd20, 32'd10});
    gap();
    chk("bp_valid", 32'(bus.valid_o), 1);
    chk("bp_ovr", 32'(bus.overrun_o), 1);
    chk("bp_period", bus.period_o, 20);
    chk("bp_high", bus.high_o, 10);
    bus.ready_i = 1'b1;
    step(2);
    chk("bp_valid_drop", 32'(bus.valid_o), 0);
    chk("bp_ovr_sticky", 32'(bus.overrun_o), 1);
    chk("drain2", 32'(sb.size()), 0);

    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    sig = 1'b1;
    step(10);
    sig = 1'b0;
    step(42);
    chk("to_early", 32'(bus.timeout_o), 0);
    step(1);
    chk("to_hit", 32'(bus.timeout_o), 1);
    wave(10, 10, 2, 1'b1);
    chk("to_cleared", 32'(bus.timeout_o), 0);
    gap();

    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    bus.ready_i = 1'b0;
    step(2);
    sig = 1'b1;
    step(10);
    sig = 1'b0;
    step(10);
    sb.push_back({32'd20, 32'd10});
    sig = 1'b1;
    step(8);
    sig = 1'b0;
    step(8);
    sb.push_back({32'd16, 32'd8});
    sig = 1'b1;
    step(2);
    chk("coin_pending", 32'(bus.valid_o), 1);
    bus.ready_i = 1'b1;
    step(1);
    chk("coin_valid", 32'(bus.valid_o), 1);
    chk("coin_period", bus.period_o, 16);
    chk("coin_high", bus.high_o, 8);
    chk("coin_ovr", 32'(bus.overrun_o), 0);
    step(1);
    chk("coin_drop", 32'(bus.valid_o), 0);

    step(5);
    rst_n = 1'b0;
    sig = 1'b0;
    #1;
    chk("mid_rst_period", bus.period_o, 0);
    chk("mid_rst_high", bus.high_o, 0);
    chk("mid_rst_valid", 32'(bus.valid_o), 0);
    step(3);
    rst_n = 1'b1;
    step(3);
    wave(10, 10, 3, 1'b1);
    gap();
    chk("drain3", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
